// File: rtl/jogo_memoria_param.sv
// Parametrised memory-game core: records the player's sequence, plays it back on the LEDs,
// then checks the reproduction with an optional per-move timeout and a running score.
module jogo_memoria_param #(
    parameter int  N_BOTOES     = 4,
    parameter int  MAX_RODADAS  = 16,
    parameter int  DEMO_RODADAS = 4,
    parameter int  T_ACESO      = 1000,
    parameter int  T_APAGADO    = 500,
    parameter int  T_TIMEOUT    = 5000,
    localparam int WB           = ($clog2(N_BOTOES) < 1) ? 1 : $clog2(N_BOTOES),
    localparam int WR           = $clog2(MAX_RODADAS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic [1:0]          configuracao,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic                pronto,
    output logic [WR-1:0]       pontuacao,
    output logic [3:0]          db_estado,
    output logic [WR-1:0]       db_endereco,
    output logic [WR-1:0]       db_limite
);

    localparam int WA     = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;
    localparam int T_MAX0 = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int T_MAX  = (T_MAX0 > T_TIMEOUT) ? T_MAX0 : T_TIMEOUT;
    localparam int WT     = $clog2(T_MAX + 1);

    localparam logic [WR-1:0]       UM       = WR'(1);
    localparam logic [WR-1:0]       L_DEMO   = WR'(DEMO_RODADAS);
    localparam logic [WR-1:0]       L_MAX    = WR'(MAX_RODADAS);
    localparam logic [WT-1:0]       FIM_ACE  = WT'(T_ACESO - 1);
    localparam logic [WT-1:0]       FIM_APA  = WT'(T_APAGADO - 1);
    localparam logic [WT-1:0]       FIM_TMO  = WT'(T_TIMEOUT - 1);
    localparam logic [N_BOTOES-1:0] LED_UM   = {{(N_BOTOES-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        ESCOLHA        = 4'h2,
        GRAVA          = 4'h3,
        MOSTRA_ACESO   = 4'h4,
        MOSTRA_APAGADO = 4'h5,
        ESPERA         = 4'h6,
        COMPARA        = 4'h7,
        GANHOU         = 4'hA,
        TIMEOUT        = 4'hD,
        PERDEU         = 4'hE
    } Estado;

    Estado               r_estado;
    Estado               w_proximo;

    logic [N_BOTOES-1:0] r_botoesAnt;
    logic [WB-1:0]       r_jogada;
    logic [WB-1:0]       r_mem [MAX_RODADAS];
    logic [WR-1:0]       r_len;
    logic [WR-1:0]       r_ptr;
    logic [WR-1:0]       r_limite;
    logic [WR-1:0]       r_pontuacao;
    logic                r_tmoEn;
    logic [WT-1:0]       r_cont;

    logic [WB-1:0]       w_indice;
    logic [WB-1:0]       w_elem;
    logic                w_jogadaDet;
    logic                w_ultimo;
    logic                w_acerto;
    logic                w_fimAceso;
    logic                w_fimApagado;
    logic                w_expirou;
    logic                w_contando;

    // A move is a rising edge of "any button pressed"; held buttons never repeat.
    assign w_jogadaDet  = (r_botoesAnt == '0) && (botoes != '0);
    assign w_elem       = r_mem[r_ptr[WA-1:0]];
    assign w_ultimo     = (r_ptr == (r_len - UM));
    assign w_acerto     = (w_elem == r_jogada);
    assign w_fimAceso   = (r_cont == FIM_ACE);
    assign w_fimApagado = (r_cont == FIM_APA);
    assign w_expirou    = r_tmoEn && (r_cont == FIM_TMO);
    assign w_contando   = (r_estado == MOSTRA_ACESO) || (r_estado == MOSTRA_APAGADO) ||
                          ((r_estado == ESPERA) && r_tmoEn);

    always_comb begin
        w_indice = '0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (botoes[i]) begin
                w_indice = WB'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            INICIAL: begin
                if (jogar) w_proximo = PREPARA;
            end
            PREPARA: begin
                w_proximo = ESCOLHA;
            end
            ESCOLHA: begin
                if (w_jogadaDet) w_proximo = GRAVA;
            end
            GRAVA: begin
                w_proximo = MOSTRA_ACESO;
            end
            MOSTRA_ACESO: begin
                if (w_fimAceso) w_proximo = MOSTRA_APAGADO;
            end
            MOSTRA_APAGADO: begin
                if (w_fimApagado) w_proximo = w_ultimo ? ESPERA : MOSTRA_ACESO;
            end
            ESPERA: begin
                // A move arriving in the expiry cycle takes precedence.
                if (w_jogadaDet)    w_proximo = COMPARA;
                else if (w_expirou) w_proximo = TIMEOUT;
            end
            COMPARA: begin
                if (!w_acerto)              w_proximo = PERDEU;
                else if (!w_ultimo)         w_proximo = ESPERA;
                else if (r_len == r_limite) w_proximo = GANHOU;
                else                        w_proximo = ESCOLHA;
            end
            GANHOU, PERDEU, TIMEOUT: begin
                if (jogar) w_proximo = PREPARA;
            end
            default: begin
                w_proximo = INICIAL;
            end
        endcase
    end

    always_comb begin
        leds    = '0;
        ganhou  = 1'b0;
        perdeu  = 1'b0;
        timeout = 1'b0;
        case (r_estado)
            ESCOLHA, ESPERA: leds    = botoes;
            MOSTRA_ACESO:    leds    = LED_UM << w_elem;
            GANHOU:          ganhou  = 1'b1;
            PERDEU:          perdeu  = 1'b1;
            TIMEOUT:         timeout = 1'b1;
            default: begin
            end
        endcase
    end

    assign pronto      = ganhou | perdeu | timeout;
    assign pontuacao   = r_pontuacao;
    assign db_estado   = r_estado;
    assign db_endereco = r_ptr;
    assign db_limite   = r_len;

    // Single timer shared by playback phases and the move timeout; restarts on every state change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cont <= '0;
        end else if ((w_proximo != r_estado) || !w_contando) begin
            r_cont <= '0;
        end else begin
            r_cont <= r_cont + WT'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_botoesAnt <= '0;
            r_jogada    <= '0;
            r_len       <= '0;
            r_ptr       <= '0;
            r_limite    <= '0;
            r_pontuacao <= '0;
            r_tmoEn     <= 1'b0;
        end else begin
            r_botoesAnt <= botoes;
            if (w_jogadaDet) begin
                r_jogada <= w_indice;
            end
            case (r_estado)
                PREPARA: begin
                    r_len       <= '0;
                    r_ptr       <= '0;
                    r_pontuacao <= '0;
                    r_limite    <= configuracao[0] ? L_DEMO : L_MAX;
                    r_tmoEn     <= configuracao[1];
                end
                GRAVA: begin
                    r_len <= r_len + UM;
                    r_ptr <= '0;
                end
                MOSTRA_APAGADO: begin
                    if (w_fimApagado) begin
                        r_ptr <= w_ultimo ? '0 : (r_ptr + UM);
                    end
                end
                COMPARA: begin
                    if (w_acerto) begin
                        if (w_ultimo) r_pontuacao <= r_len;
                        else          r_ptr       <= r_ptr + UM;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sequence storage survives between games, so it carries no reset.
    always_ff @(posedge clock) begin
        if (r_estado == GRAVA) begin
            r_mem[r_len[WA-1:0]] <= r_jogada;
        end
    end

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Bench for jogo_memoria_param: scenario tasks with randomized presses checked against
// a sequence-queue model of the game rules.
module tb_jogo_memoria_param;

    localparam int N    = 4;
    localparam int MAXR = 16;
    localparam int DEMO = 4;
    localparam int TA   = 4;
    localparam int TP   = 2;
    localparam int TT   = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar;
    logic [1:0] configuracao;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic       pronto;
    logic [4:0] pontuacao;
    logic [3:0] db_estado;
    logic [4:0] db_endereco;
    logic [4:0] db_limite;

    int checks   = 0;
    int failures = 0;
    int seq[$];
    int limite;

    jogo_memoria_param #(
        .N_BOTOES(N), .MAX_RODADAS(MAXR), .DEMO_RODADAS(DEMO),
        .T_ACESO(TA), .T_APAGADO(TP), .T_TIMEOUT(TT)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .configuracao(configuracao),
        .botoes(botoes), .leds(leds), .ganhou(ganhou), .perdeu(perdeu),
        .timeout(timeout), .pronto(pronto), .pontuacao(pontuacao),
        .db_estado(db_estado), .db_endereco(db_endereco), .db_limite(db_limite)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Button word whose lowest set bit is m, sometimes with extra higher buttons pressed.
    function automatic logic [3:0] pressVal(input int m);
        logic [3:0] one;
        logic [3:0] mask;
        logic [3:0] extra;
        one   = 4'b0001 << m;
        mask  = ~((one << 1) - 4'd1);
        extra = 4'($urandom);
        if ($urandom_range(0, 1) == 0) extra = 4'b0000;
        return one | (extra & mask);
    endfunction

    function automatic logic [3:0] expectNext(input int k, input bit correct);
        if (!correct) return 4'hE;
        if (k < seq.size() - 1) return 4'h6;
        if (seq.size() == limite) return 4'hA;
        return 4'h2;
    endfunction

    task automatic hardReset();
        reset = 1'b1;
        jogar = 1'b0;
        botoes = 4'b0000;
        #2;
        reset = 1'b0;
        tick();
        seq.delete();
    endtask

    task automatic startGame(input logic [1:0] cfg, output logic [3:0] stA, output logic [3:0] stB);
        configuracao = cfg;
        jogar = 1'b1;
        tick();
        stA = db_estado;
        jogar = 1'b0;
        tick();
        stB = db_estado;
        seq.delete();
        limite = cfg[0] ? DEMO : MAXR;
    endtask

    task automatic watchPlayback(output int n, output int errs);
        int idx;
        int ph;
        logic [3:0] e;
        logic [3:0] es;
        n = 0;
        errs = 0;
        while ((db_estado == 4'h4 || db_estado == 4'h5) && n < 1000) begin
            idx = n / (TA + TP);
            ph  = n % (TA + TP);
            es  = (ph < TA) ? 4'h4 : 4'h5;
            if (idx >= seq.size()) begin
                e = 4'b0000;
                errs++;
            end else begin
                e = (ph < TA) ? (4'b0001 << seq[idx]) : 4'b0000;
            end
            if (leds !== e || db_estado !== es) errs++;
            n++;
            tick();
        end
    endtask

    task automatic addMove(input int m, output logic [3:0] stG, output int nPlay, output int ledErrs);
        botoes = pressVal(m);
        tick();
        stG = db_estado;
        botoes = 4'b0000;
        seq.push_back(m);
        tick();
        watchPlayback(nPlay, ledErrs);
    endtask

    task automatic reproduce(input int v, output logic [3:0] stC, output logic [3:0] stN,
                             output logic [3:0] pressed, output logic [3:0] mirror);
        pressed = pressVal(v);
        botoes = pressed;
        #1;
        mirror = leds;
        tick();
        stC = db_estado;
        botoes = 4'b0000;
        tick();
        stN = db_estado;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        jogar = 1'b0;
        configuracao = 2'b00;
        botoes = 4'b0000;
        tick();
        tick();
        checks++;
        if (db_estado !== 4'h0 || leds !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: got estado=%h leds=%b want estado=0 leds=0000", db_estado, leds);
        end
        checks++;
        if ({ganhou, perdeu, timeout, pronto} !== 4'b0000 || pontuacao !== 5'd0 ||
            db_endereco !== 5'd0 || db_limite !== 5'd0) begin
            failures++;
            $display("FAIL reset_outputs: got res=%b pont=%0d end=%0d lim=%0d want all 0",
                     {ganhou, perdeu, timeout, pronto}, pontuacao, db_endereco, db_limite);
        end
        #2;
        reset = 1'b0;
        tick();
        botoes = 4'b0100;
        tick();
        tick();
        botoes = 4'b0000;
        tick();
        checks++;
        if (db_estado !== 4'h0) begin
            failures++;
            $display("FAIL idle_ignores_buttons: got estado=%h want 0", db_estado);
        end
    endtask

    task automatic test_demo_win();
        logic [3:0] a, b, g, c, nx, p, mi;
        int n, e;
        hardReset();
        startGame(2'b01, a, b);
        checks++;
        if (a !== 4'h1 || b !== 4'h2) begin
            failures++;
            $display("FAIL demo_start: got %h,%h want 1,2", a, b);
        end
        checks++;
        if (pontuacao !== 5'd0 || db_limite !== 5'd0) begin
            failures++;
            $display("FAIL demo_prepare: got pont=%0d len=%0d want 0,0", pontuacao, db_limite);
        end
        for (int r = 0; r < 4; r++) begin
            addMove(r, g, n, e);
            checks++;
            if (g !== 4'h3) begin
                failures++;
                $display("FAIL demo_grava r%0d: got %h want 3", r, g);
            end
            checks++;
            if (n !== (TA + TP) * (r + 1) || e !== 0) begin
                failures++;
                $display("FAIL demo_playback r%0d: got cycles=%0d errs=%0d want cycles=%0d errs=0",
                         r, n, e, (TA + TP) * (r + 1));
            end
            checks++;
            if (db_estado !== 4'h6 || db_limite !== 5'(r + 1)) begin
                failures++;
                $display("FAIL demo_espera r%0d: got estado=%h len=%0d want 6,%0d", r, db_estado, db_limite, r + 1);
            end
            for (int k = 0; k <= r; k++) begin
                checks++;
                if (db_endereco !== 5'(k)) begin
                    failures++;
                    $display("FAIL demo_ptr r%0d k%0d: got %0d want %0d", r, k, db_endereco, k);
                end
                reproduce(seq[k], c, nx, p, mi);
                checks++;
                if (mi !== p || c !== 4'h7 || nx !== expectNext(k, 1'b1)) begin
                    failures++;
                    $display("FAIL demo_compare r%0d k%0d: got leds=%b cmp=%h next=%h want leds=%b cmp=7 next=%h",
                             r, k, mi, c, nx, p, expectNext(k, 1'b1));
                end
            end
            checks++;
            if (pontuacao !== 5'(r + 1)) begin
                failures++;
                $display("FAIL demo_score r%0d: got %0d want %0d", r, pontuacao, r + 1);
            end
        end
        checks++;
        if (db_estado !== 4'hA || {ganhou, perdeu, timeout, pronto} !== 4'b1001 || pontuacao !== 5'd4) begin
            failures++;
            $display("FAIL demo_win: got estado=%h res=%b pont=%0d want A,1001,4",
                     db_estado, {ganhou, perdeu, timeout, pronto}, pontuacao);
        end
    endtask

    task automatic test_random_games();
        logic [3:0] a, b, g, c, nx, p, mi;
        int n, e, failRound, failPos, roundsDone, v;
        bit lost, bad;
        for (int gm = 0; gm < 4; gm++) begin
            startGame(2'b01, a, b);
            checks++;
            if (a !== 4'h1 || pronto !== 1'b0) begin
                failures++;
                $display("FAIL rnd_restart g%0d: got estado=%h pronto=%b want 1,0", gm, a, pronto);
            end
            failRound = $urandom_range(0, 4);
            lost = 1'b0;
            roundsDone = 0;
            for (int r = 0; r < limite && !lost; r++) begin
                failPos = $urandom_range(0, r);
                addMove($urandom_range(0, 3), g, n, e);
                checks++;
                if (g !== 4'h3 || n !== (TA + TP) * (r + 1) || e !== 0) begin
                    failures++;
                    $display("FAIL rnd_playback g%0d r%0d: got st=%h cycles=%0d errs=%0d want 3,%0d,0",
                             gm, r, g, n, e, (TA + TP) * (r + 1));
                end
                for (int k = 0; k <= r && !lost; k++) begin
                    bad = (r == failRound) && (k == failPos);
                    v = bad ? (seq[k] + $urandom_range(1, 3)) % 4 : seq[k];
                    reproduce(v, c, nx, p, mi);
                    checks++;
                    if (c !== 4'h7 || nx !== expectNext(k, !bad)) begin
                        failures++;
                        $display("FAIL rnd_compare g%0d r%0d k%0d: got cmp=%h next=%h want 7,%h",
                                 gm, r, k, c, nx, expectNext(k, !bad));
                    end
                    if (bad) lost = 1'b1;
                end
                if (!lost) roundsDone++;
            end
            checks++;
            if (pontuacao !== 5'(roundsDone) || db_estado !== (lost ? 4'hE : 4'hA) || pronto !== 1'b1) begin
                failures++;
                $display("FAIL rnd_result g%0d: got pont=%0d estado=%h pronto=%b want %0d,%h,1",
                         gm, pontuacao, db_estado, pronto, roundsDone, lost ? 4'hE : 4'hA);
            end
        end
    endtask

    task automatic test_error();
        logic [3:0] a, b, g, c, nx, p, mi;
        int n, e;
        hardReset();
        startGame(2'b00, a, b);
        addMove(2, g, n, e);
        reproduce(2, c, nx, p, mi);
        checks++;
        if (nx !== 4'h2 || pontuacao !== 5'd1) begin
            failures++;
            $display("FAIL err_round1: got next=%h pont=%0d want 2,1", nx, pontuacao);
        end
        addMove(1, g, n, e);
        reproduce(2, c, nx, p, mi);
        checks++;
        if (nx !== 4'h6 || db_endereco !== 5'd1) begin
            failures++;
            $display("FAIL err_ptr0: got next=%h ptr=%0d want 6,1", nx, db_endereco);
        end
        reproduce(2, c, nx, p, mi);
        checks++;
        if (c !== 4'h7 || nx !== 4'hE) begin
            failures++;
            $display("FAIL err_compare: got cmp=%h next=%h want 7,E", c, nx);
        end
        checks++;
        if ({ganhou, perdeu, timeout, pronto} !== 4'b0101 || pontuacao !== 5'd1) begin
            failures++;
            $display("FAIL err_result: got res=%b pont=%0d want 0101,1", {ganhou, perdeu, timeout, pronto}, pontuacao);
        end
    endtask

    task automatic test_restart();
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        checks++;
        if (db_estado !== 4'h1 || perdeu !== 1'b0 || pronto !== 1'b0) begin
            failures++;
            $display("FAIL restart: got estado=%h perdeu=%b pronto=%b want 1,0,0", db_estado, perdeu, pronto);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] a, b, g;
        int n, e, cnt;
        hardReset();
        startGame(2'b10, a, b);
        addMove(3, g, n, e);
        cnt = 0;
        while (db_estado == 4'h6 && cnt < 200) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== TT || db_estado !== 4'hD || {timeout, pronto} !== 2'b11) begin
            failures++;
            $display("FAIL timeout_expiry: got cycles=%0d estado=%h tp=%b want %0d,D,11",
                     cnt, db_estado, {timeout, pronto}, TT);
        end
        startGame(2'b00, a, b);
        checks++;
        if (a !== 4'h1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_restart: got estado=%h timeout=%b want 1,0", a, timeout);
        end
        addMove($urandom_range(0, 3), g, n, e);
        cnt = 0;
        repeat (100) begin
            if (db_estado == 4'h6) cnt++;
            tick();
        end
        checks++;
        if (cnt !== 100 || db_estado !== 4'h6) begin
            failures++;
            $display("FAIL timeout_disabled: got espera_cycles=%0d estado=%h want 100,6", cnt, db_estado);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] a, b, g;
        int n, e, gravas, m;
        hardReset();
        startGame(2'b10, a, b);
        m = $urandom_range(0, 3);
        addMove(m, g, n, e);
        repeat (TT - 1) tick();
        checks++;
        if (db_estado !== 4'h6) begin
            failures++;
            $display("FAIL simul_prewait: got estado=%h want 6", db_estado);
        end
        botoes = pressVal(m);
        tick();
        checks++;
        if (db_estado !== 4'h7) begin
            failures++;
            $display("FAIL simul_move_wins: got estado=%h want 7", db_estado);
        end
        gravas = 0;
        repeat (9) begin
            tick();
            if (db_estado == 4'h3) gravas++;
        end
        checks++;
        if (gravas !== 0 || db_estado !== 4'h2 || pontuacao !== 5'd1) begin
            failures++;
            $display("FAIL simul_held: got gravas=%0d estado=%h pont=%0d want 0,2,1", gravas, db_estado, pontuacao);
        end
        botoes = 4'b0000;
        tick();
        addMove($urandom_range(0, 3), g, n, e);
        checks++;
        if (g !== 4'h3 || e !== 0) begin
            failures++;
            $display("FAIL simul_release: got st=%h errs=%0d want 3,0", g, e);
        end
    endtask

    task automatic test_reset_mid_playback();
        logic [3:0] a, b, g, c, nx, p, mi;
        int n, e;
        hardReset();
        startGame(2'b01, a, b);
        addMove(1, g, n, e);
        reproduce(1, c, nx, p, mi);
        botoes = pressVal(3);
        tick();
        botoes = 4'b0000;
        tick();
        tick();
        checks++;
        if (db_estado !== 4'h4 || pontuacao !== 5'd1) begin
            failures++;
            $display("FAIL midplay_pre: got estado=%h pont=%0d want 4,1", db_estado, pontuacao);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (db_estado !== 4'h0 || leds !== 4'h0 || {ganhou, perdeu, timeout, pronto} !== 4'b0000 ||
            pontuacao !== 5'd0 || db_limite !== 5'd0 || db_endereco !== 5'd0) begin
            failures++;
            $display("FAIL midplay_reset: got estado=%h leds=%b res=%b pont=%0d lim=%0d end=%0d want all 0",
                     db_estado, leds, {ganhou, perdeu, timeout, pronto}, pontuacao, db_limite, db_endereco);
        end
        #1;
        reset = 1'b0;
        tick();
        startGame(2'b01, a, b);
        checks++;
        if (a !== 4'h1 || b !== 4'h2 || pontuacao !== 5'd0) begin
            failures++;
            $display("FAIL midplay_fresh: got %h,%h pont=%0d want 1,2,0", a, b, pontuacao);
        end
        addMove(2, g, n, e);
        checks++;
        if (g !== 4'h3 || n !== TA + TP || e !== 0 || db_estado !== 4'h6) begin
            failures++;
            $display("FAIL midplay_round: got st=%h cycles=%0d errs=%0d end=%h want 3,%0d,0,6",
                     g, n, e, db_estado, TA + TP);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, failures so far=%0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_demo_win();
        test_random_games();
        test_error();
        test_restart();
        test_timeout();
        test_simultaneous();
        test_reset_mid_playback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jogo_memoria_param.md
# jogo_memoria_param

Parametrised memory-game core, the next generation of the board-level memory game. It generalises button/colour count, round limits, display timing and timeout length. It adds a live score and a lowest-index priority rule for simultaneous presses. FSM, sequence RAM, comparators and timers are all internal; board-level 7-segment decoding stays outside this block.

## Interface
Parameters:
- N_BOTOES, 4: number of buttons/colours; ≥2. WB = max(1, clog2(N_BOTOES)).
- MAX_RODADAS, 16: sequence length limit in full mode. WR = clog2(MAX_RODADAS+1).
- DEMO_RODADAS, 4: limit in demo mode; 1 ≤ DEMO_RODADAS ≤ MAX_RODADAS.
- T_ACESO, 1000: cycles each element is lit during playback; ≥1.
- T_APAGADO, 500: dark cycles after each lit element; ≥1.
- T_TIMEOUT, 5000: cycles allowed per player move; ≥2.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- jogar, in, 1: start/restart request, level sampled each cycle.
- configuracao, in, 2: bit0 = 1 selects demo (DEMO_RODADAS), 0 selects full (MAX_RODADAS); bit1 = 1 enables timeout. Latched in PREPARA only.
- botoes, in, N_BOTOES: player buttons, already synchronised and debounced upstream.
- leds, out, N_BOTOES: one-hot playback; mirrors botoes in ESCOLHA and ESPERA; 0 otherwise.
- ganhou, perdeu, timeout, out, 1 each: final-result levels.
- pronto, out, 1: high in any final state.
- pontuacao, out, WR: rounds completed in the current or last game.
- db_estado, out, 4: state code.
- db_endereco, out, WR: playback/compare pointer.
- db_limite, out, WR: current sequence length.

## Operation
- Move detection: the block registers botoes each cycle. A move is detected when the previous sample is all-zero and the current sample is non-zero. The move value is the index of the lowest set bit. Held buttons produce no further moves.
- Sequence RAM: MAX_RODADAS × WB registers, written only in GRAVA. The RAM is not cleared between games.
- States and codes:
  - INICIAL (0): idle.
  - PREPARA (1): len←0, ptr←0, pontuacao←0, latch configuracao into limite L and tmo_en.
  - ESCOLHA (2): wait for a move. No timeout in this state.
  - GRAVA (3): mem[len]←move, len←len+1, ptr←0.
  - MOSTRA_ACESO (4): leds = one-hot(mem[ptr]) for T_ACESO cycles.
  - MOSTRA_APAGADO (5): leds = 0 for T_APAGADO cycles. Then: if ptr = len−1, ptr←0 and go to ESPERA; else ptr←ptr+1 and go to MOSTRA_ACESO.
  - ESPERA (6): wait for a move; the timer runs only if tmo_en.
  - COMPARA (7): compare the move with mem[ptr]. On mismatch, go to PERDEU. On match with ptr < len−1, ptr←ptr+1 and go to ESPERA. On match with ptr = len−1: pontuacao←len, then go to GANHOU if len = L, else ESCOLHA.
  - GANHOU (A), PERDEU (E), TIMEOUT (D): final states.
- Transitions from idle and final states:
  - INICIAL→PREPARA when jogar = 1.
  - A final state→PREPARA when jogar = 1 (restart).
  - Final states and INICIAL ignore botoes.
- Result outputs:
  - ganhou, perdeu and timeout are each high only in their own state.
  - pronto = ganhou | perdeu | timeout.
  - All result outputs are held until PREPARA.
- Reset, asynchronous, effective at any time (including mid-playback or mid-compare): state INICIAL, all outputs 0, pontuacao 0, len 0, ptr 0, timers 0, button sample register 0.

## Timing
- jogar high in cycle n puts the block in PREPARA at n+1 and ESCOLHA at n+2.
- A move detected in cycle m puts the block in GRAVA or COMPARA at m+1.
- GRAVA→MOSTRA_ACESO takes 1 cycle.
- Each playback element takes exactly T_ACESO + T_APAGADO cycles. Timers reload on state entry.
- Timeout timer:
  - Cleared on every entry to ESPERA.
  - Increments each ESPERA cycle with no move.
  - At count T_TIMEOUT−1 with no move, the next state is TIMEOUT, giving exactly T_TIMEOUT ESPERA cycles.
  - If a move and expiry occur in the same cycle, the move wins.
- configuracao changes after PREPARA have no effect until the next game.
- L = MAX_RODADAS: len reaches MAX_RODADAS exactly at the win check. There is no write beyond index MAX_RODADAS−1 and no pointer wrap.
- Multi-bit press, e.g. botoes = 0110: move = 1.

## Test plan
Bench parameters: N_BOTOES=4, T_ACESO=4, T_APAGADO=2, T_TIMEOUT=20, DEMO_RODADAS=4.
- Demo win: configuracao=01, jogar. Choose 0,1,2,3 and reproduce each round correctly. Required: ganhou=pronto=1, pontuacao=4, db_estado=A. Playback for len=3 lasts 18 cycles.
- Error: configuracao=00. Sequence [2], reproduce 2, add 1, press 2 at ptr 1. Required: perdeu=1, pontuacao=1, db_estado=E.
- Timeout: configuracao=10. Choose 3, no press after playback. Required: TIMEOUT entered exactly 20 cycles after ESPERA entry. Repeat with configuracao=00: stays in ESPERA for 100 cycles.
- Simultaneity: press in the same cycle the timer expires. Required: COMPARA, not TIMEOUT. Hold the button for 10 cycles: exactly one move counted.
- Reset mid-playback: assert reset in MOSTRA_ACESO. Required: all outputs 0 immediately, db_estado=0. A subsequent jogar starts a fresh game with pontuacao=0.
- Restart: jogar in PERDEU. Required: PREPARA next cycle and perdeu drops to 0.
